jmp_ctrl: RTL and testbench

Control-transfer sequencer for the rv32 five-stage pipeline. It sits after the Execute-stage jump decoder: it takes the resolved taken/not-taken flag and the computed target, drives the Fetch PC-select and redirect target, and flushes the wrong-path instructions in Decode and Execute. If a redirect resolves while the pipeline is frozen by a memory stall, the block holds it pending until the stall releases, so no redirect is ever lost or issued twice.

---
 rtl/jmp_ctrl.sv | 87 ++++++++
 tb/tb_jmp_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/jmp_ctrl.sv
// Control-transfer sequencer: issues Fetch redirects and D/E flushes for
// taken jumps. A redirect that resolves during a stall is held until the stall
// releases. Optional redirect counter is enabled by defining JMP_PERF_EN.
module jmp_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            PCJmpE,
    input  logic [XLEN-1:0] PCTargetE,
    input  logic            StallE,
    output logic            PCSrcF,
    output logic [XLEN-1:0] PCRedirF,
    output logic            FlushD,
    output logic            FlushE,
    output logic            PendJmp,
    output logic [31:0]     JmpCount
);

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] PEND   = 2'b01;
    localparam logic [1:0] SHADOW = 2'b10;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] tgt_q, tgt_d;
    logic            redir;

    always_comb begin
        state_d = state_q;
        tgt_d   = tgt_q;
        redir   = 1'b0;
        case (state_q)
            IDLE: begin
                if (PCJmpE && !StallE) begin
                    redir   = 1'b1;
                    state_d = SHADOW;
                end else if (PCJmpE) begin
                    tgt_d   = PCTargetE;
                    state_d = PEND;
                end
            end
            // Execute still holds the same jump while stalled, so PCJmpE is ignored here.
            PEND: begin
                if (!StallE) begin
                    redir   = 1'b1;
                    state_d = SHADOW;
                end
            end
            SHADOW: begin
                if (!StallE) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // Keep the fetch interface quiet while reset is asserted.
        if (!rst_n) redir = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
        end
    end

    assign PCSrcF   = redir;
    assign FlushD   = redir;
    assign FlushE   = redir;
    assign PCRedirF = !redir ? '0 : ((state_q == PEND) ? tgt_q : PCTargetE);
    assign PendJmp  = (state_q == PEND);

`ifdef JMP_PERF_EN
    logic [31:0] jmp_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     jmp_cnt_q <= '0;
        else if (redir) jmp_cnt_q <= jmp_cnt_q + 32'd1;
    end

    assign JmpCount = jmp_cnt_q;
`else
    assign JmpCount = '0;
`endif

endmodule

// File: tb/tb_jmp_ctrl.sv
// Randomized self-checking bench for jmp_ctrl against a rule-level reference model.
module tb_jmp_ctrl;

    logic        clk;
    logic        rst_n;
    logic        PCJmpE;
    logic [31:0] PCTargetE;
    logic        StallE;
    logic        PCSrcF;
    logic [31:0] PCRedirF;
    logic        FlushD;
    logic        FlushE;
    logic        PendJmp;
    logic [31:0] JmpCount;

    int checks   = 0;
    int failures = 0;

    // Reference model: a pending-target queue, a flag meaning "the next
    // unstalled cycle is the flushed bubble", and a redirect count.
    logic [31:0] pq[$];
    bit          skip;
    logic [31:0] mcnt;

    jmp_ctrl #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .PCJmpE   (PCJmpE),
        .PCTargetE(PCTargetE),
        .StallE   (StallE),
        .PCSrcF   (PCSrcF),
        .PCRedirF (PCRedirF),
        .FlushD   (FlushD),
        .FlushE   (FlushE),
        .PendJmp  (PendJmp),
        .JmpCount (JmpCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt();
`ifdef JMP_PERF_EN
        return mcnt;
`else
        return 32'd0;
`endif
    endfunction

    // One clock: drive at negedge, compare combinational outputs, advance model.
    task automatic step(input bit jmp, input logic [31:0] tgt, input bit stall);
        bit          e_red;
        logic [31:0] e_tgt;
        bit          e_pend;
        @(negedge clk);
        PCJmpE = jmp; PCTargetE = tgt; StallE = stall;
        #1;
        e_red  = 1'b0;
        e_tgt  = 32'd0;
        e_pend = (pq.size() != 0);
        if (skip) begin
            if (!stall) skip = 1'b0;
        end else if (pq.size() != 0) begin
            if (!stall) begin
                e_red = 1'b1; e_tgt = pq.pop_front(); skip = 1'b1;
            end
        end else if (jmp) begin
            if (stall) pq.push_back(tgt);
            else begin
                e_red = 1'b1; e_tgt = tgt; skip = 1'b1;
            end
        end
        chk("PCSrcF",   {63'd0, PCSrcF},  {63'd0, e_red});
        chk("FlushD",   {63'd0, FlushD},  {63'd0, e_red});
        chk("FlushE",   {63'd0, FlushE},  {63'd0, e_red});
        chk("PCRedirF", {32'd0, PCRedirF}, {32'd0, e_tgt});
        chk("PendJmp",  {63'd0, PendJmp}, {63'd0, e_pend});
        chk("JmpCount", {32'd0, JmpCount}, {32'd0, exp_cnt()});
        if (e_red) mcnt = mcnt + 32'd1;
    endtask

    task automatic do_reset(input bit jmp_during);
        @(negedge clk);
        PCJmpE = jmp_during; PCTargetE = 32'h0000_0400; StallE = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_PCSrcF",   {63'd0, PCSrcF},  64'd0);
        chk("rst_FlushD",   {63'd0, FlushD},  64'd0);
        chk("rst_FlushE",   {63'd0, FlushE},  64'd0);
        chk("rst_PCRedirF", {32'd0, PCRedirF}, 64'd0);
        chk("rst_PendJmp",  {63'd0, PendJmp}, 64'd0);
        chk("rst_JmpCount", {32'd0, JmpCount}, 64'd0);
        pq.delete(); skip = 1'b0; mcnt = 32'd0;
        @(negedge clk);
        PCJmpE = 1'b0;
        rst_n  = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0; PCJmpE = 1'b0; PCTargetE = 32'd0; StallE = 1'b0;
        skip = 1'b0; mcnt = 32'd0;
        repeat (2) @(posedge clk);
        do_reset(1'b1);

        // Unstalled jump: zero-latency redirect, then quiet.
        step(1, 32'h100, 0);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);

        // Stalled jump is held; target change during stall is ignored.
        step(1, 32'h200, 1);
        step(1, 32'h999, 1);
        step(1, 32'h999, 1);
        step(0, 32'h999, 1);
        step(0, 32'h999, 0);
        step(0, 32'h0, 0);

        // Jump held two cycles: second cycle is the shadow.
        step(1, 32'h180, 0);
        step(1, 32'h184, 0);
        step(0, 32'h0, 0);

        // Shadow extended by stall, then a new jump after returning to IDLE.
        step(1, 32'h280, 0);
        step(1, 32'h300, 1);
        step(1, 32'h300, 1);
        step(1, 32'h300, 0);
        step(1, 32'h300, 0);
        step(0, 32'h0, 0);

        // Stall toggling in PEND: exactly one redirect.
        step(1, 32'h500, 1);
        step(0, 32'h0, 1);
        step(0, 32'h0, 0);
        step(0, 32'h0, 1);
        step(0, 32'h0, 0);
        step(0, 32'h0, 0);

        // Reset mid-PEND discards the pending redirect.
        step(1, 32'h400, 1);
        step(0, 32'h400, 1);
        do_reset(1'b0);
        step(0, 32'h400, 0);
        step(0, 32'h400, 0);

`ifdef JMP_PERF_EN
        // Counter wrap from all-ones.
        @(negedge clk);
        force dut.jmp_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.jmp_cnt_q;
        mcnt = 32'hFFFF_FFFF;
        step(1, 32'h600, 0);
        step(0, 32'h0, 0);
`endif

        // Random traffic with occasional reset.
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset($urandom_range(0, 1) == 1);
            else step($urandom_range(0, 9) < 4, $urandom, $urandom_range(0, 9) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
